// File: rtl/mips_store_logger.sv
// Passive store logger: snoops the core's CS/WE bus and queues each store (address, data) in a FIFO.
// Optional STORE_LOGGER_TIMESTAMP_EN adds a free-running cycle counter captured with each entry (rd_time).
`timescale 1ns/1ps
module mips_store_logger #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          CS,
    input  logic          WE,
    input  logic [31:0]   Addr_In,
    input  logic [31:0]   Data_In,
    input  logic          rd_en,
    output logic          rd_valid,
    output logic [31:0]   rd_addr,
    output logic [31:0]   rd_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
`ifdef STORE_LOGGER_TIMESTAMP_EN
    output logic [31:0]   rd_time,
`endif
    output logic          overflow
);

`ifdef STORE_LOGGER_TIMESTAMP_EN
    localparam int EW = 96;
`else
    localparam int EW = 64;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          we_d;
    logic          push, pop_ok, push_ok;
    logic [EW-1:0] wr_entry;

    // Consumer handshake: rd_en is a pop request honoured only when not empty;
    // rd_valid pulses for exactly the cycle after an accepted pop, with rd_addr/rd_data
    // holding that entry. There is no backpressure toward the core: stores arriving
    // while full are dropped and flagged on the sticky overflow bit.
    assign push    = CS & WE & ~we_d;
    assign pop_ok  = rd_en & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));

`ifdef STORE_LOGGER_TIMESTAMP_EN
    logic [31:0] cyc_cnt;
    assign wr_entry = {cyc_cnt, Data_In, Addr_In};

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            rd_time <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (pop_ok)
                rd_time <= mem[rd_ptr][95:64];
        end
    end
`else
    assign wr_entry = {Data_In, Addr_In};
`endif

    // Storage array carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            we_d     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else begin
            we_d     <= WE;
            rd_valid <= pop_ok;
            count    <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (push && !push_ok)
                overflow <= 1'b1;
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_addr <= mem[rd_ptr][31:0];
                rd_data <= mem[rd_ptr][63:32];
            end
        end
    end

endmodule

// File: tb/tb_mips_store_logger.sv
// Bench for mips_store_logger: scoreboard of expected (addr, data) pushed on each store, popped on each read.
// Build with STORE_LOGGER_TIMESTAMP_EN to also exercise rd_time.
`timescale 1ns/1ps
module tb_mips_store_logger;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        CS = 1'b0, WE = 1'b0, rd_en = 1'b0;
    logic [31:0] Addr_In = '0, Data_In = '0;
    logic        rd_valid, empty, full, overflow;
    logic [31:0] rd_addr, rd_data;
    logic [AW:0] count;
`ifdef STORE_LOGGER_TIMESTAMP_EN
    logic [31:0] rd_time;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic        exp_ovf = 1'b0;

    mips_store_logger #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .rst(rst), .CS(CS), .WE(WE), .Addr_In(Addr_In), .Data_In(Data_In),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .count(count), .empty(empty), .full(full),
`ifdef STORE_LOGGER_TIMESTAMP_EN
        .rd_time(rd_time),
`endif
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    // One WE pulse then one idle cycle; scoreboard models the FIFO occupancy.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        CS = 1'b1; WE = 1'b1; Addr_In = a; Data_In = d;
        @(posedge CLK); #1;
        CS = 1'b0; WE = 1'b0;
        if (exp_addr_q.size() < DEPTH) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(d);
        end else begin
            exp_ovf = 1'b1;
        end
        @(posedge CLK); #1;
    endtask

    task automatic do_pop(output logic v, output logic [31:0] a, output logic [31:0] d);
        rd_en = 1'b1;
        @(posedge CLK); #1;
        rd_en = 1'b0;
        v = rd_valid; a = rd_addr; d = rd_data;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== '0 || overflow !== 1'b0 ||
            rd_valid !== 1'b0 || rd_addr !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset: empty=%b full=%b count=%0d ovf=%b vld=%b addr=%h data=%h, required 1 0 0 0 0 0 0",
                     empty, full, count, overflow, rd_valid, rd_addr, rd_data);
        end
        rst = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_single();
        logic v; logic [31:0] a, d, ea, ed;
        do_store(32'h14, 32'h6);
        @(posedge CLK); #1;
        checks++;
        if (count !== 5'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL single_count: count=%0d empty=%b, required 1 0", count, empty);
        end
        do_pop(v, a, d);
        ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
        checks++;
        if (v !== 1'b1 || a !== ea || d !== ed) begin
            errors++;
            $display("FAIL single_pop: vld=%b addr=%h data=%h, required 1 %h %h", v, a, d, ea, ed);
        end
        checks++;
        if (count !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL single_drained: count=%0d empty=%b, required 0 1", count, empty);
        end
        @(posedge CLK); #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_addr !== ea) begin
            errors++;
            $display("FAIL single_vld_drop: vld=%b addr=%h, required 0 %h", rd_valid, rd_addr, ea);
        end
    endtask

    task automatic test_we_held();
        logic v; logic [31:0] a, d, ea, ed;
        CS = 1'b1; WE = 1'b1; Addr_In = 32'h40; Data_In = 32'h12;
        repeat (4) @(posedge CLK);
        #1; CS = 1'b0; WE = 1'b0;
        exp_addr_q.push_back(32'h40); exp_data_q.push_back(32'h12);
        @(posedge CLK); #1;
        checks++;
        if (count !== 5'd1) begin
            errors++;
            $display("FAIL we_held_count: count=%0d, required 1", count);
        end
        do_pop(v, a, d);
        ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
        checks++;
        if (v !== 1'b1 || a !== ea || d !== ed) begin
            errors++;
            $display("FAIL we_held_pop: vld=%b addr=%h data=%h, required 1 %h %h", v, a, d, ea, ed);
        end
        CS = 1'b0; WE = 1'b1; Addr_In = 32'h44; Data_In = 32'h13;
        repeat (4) @(posedge CLK);
        #1; WE = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (count !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL cs_low: count=%0d empty=%b, required 0 1", count, empty);
        end
    endtask

    task automatic test_overflow();
        logic v; logic [31:0] a, d, ea, ed;
        for (int i = 1; i <= DEPTH; i++)
            do_store(32'h100 + 32'(i) * 4, 32'(i));
        do_store(32'h200, 32'h120);
        checks++;
        if (full !== 1'b1 || overflow !== exp_ovf || exp_ovf !== 1'b1 || count !== 5'(DEPTH)) begin
            errors++;
            $display("FAIL overflow_state: full=%b ovf=%b count=%0d, required 1 1 %0d", full, overflow, count, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_pop(v, a, d);
            ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
            checks++;
            if (v !== 1'b1 || a !== ea || d !== ed) begin
                errors++;
                $display("FAIL overflow_drain[%0d]: vld=%b addr=%h data=%h, required 1 %h %h", i, v, a, d, ea, ed);
            end
        end
        checks++;
        if (overflow !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%b empty=%b, required 1 1", overflow, empty);
        end
    endtask

    task automatic test_async_reset();
        logic v; logic [31:0] a, d;
        for (int i = 0; i < 4; i++)
            do_store(32'h300 + 32'(i) * 4, 32'hA0 + 32'(i));
        do_pop(v, a, d);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1 || count !== '0 || rd_valid !== 1'b0 || overflow !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: empty=%b count=%0d vld=%b ovf=%b full=%b, required 1 0 0 0 0",
                     empty, count, rd_valid, overflow, full);
        end
        exp_addr_q.delete(); exp_data_q.delete(); exp_ovf = 1'b0;
        #1 rst = 1'b0;
        @(posedge CLK); #1;
        do_pop(v, a, d);
        checks++;
        if (v !== 1'b0 || a !== '0 || d !== '0) begin
            errors++;
            $display("FAIL pop_after_reset: vld=%b addr=%h data=%h, required 0 0 0", v, a, d);
        end
    endtask

    task automatic test_full_push_pop();
        logic v; logic [31:0] a, d, ea, ed;
        for (int i = 1; i <= DEPTH; i++)
            do_store(32'h100 + 32'(i) * 4, 32'(i));
        CS = 1'b1; WE = 1'b1; Addr_In = 32'h60; Data_In = 32'h18; rd_en = 1'b1;
        @(posedge CLK); #1;
        CS = 1'b0; WE = 1'b0; rd_en = 1'b0;
        ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
        exp_addr_q.push_back(32'h60); exp_data_q.push_back(32'h18);
        checks++;
        if (rd_valid !== 1'b1 || rd_addr !== ea || rd_data !== ed) begin
            errors++;
            $display("FAIL full_pp_pop: vld=%b addr=%h data=%h, required 1 %h %h", rd_valid, rd_addr, rd_data, ea, ed);
        end
        checks++;
        if (count !== 5'(DEPTH) || overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_pp_state: count=%0d ovf=%b full=%b, required %0d 0 1", count, overflow, full, DEPTH);
        end
        @(posedge CLK); #1;
        for (int i = 0; i < DEPTH; i++) begin
            do_pop(v, a, d);
            ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
            checks++;
            if (v !== 1'b1 || a !== ea || d !== ed) begin
                errors++;
                $display("FAIL wrap_drain[%0d]: vld=%b addr=%h data=%h, required 1 %h %h", i, v, a, d, ea, ed);
            end
        end
    endtask

    task automatic test_empty_push_pop();
        logic v; logic [31:0] a, d, ea, ed;
        @(posedge CLK); #1;
        CS = 1'b1; WE = 1'b1; Addr_In = 32'h70; Data_In = 32'h55; rd_en = 1'b1;
        @(posedge CLK); #1;
        CS = 1'b0; WE = 1'b0; rd_en = 1'b0;
        exp_addr_q.push_back(32'h70); exp_data_q.push_back(32'h55);
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd1) begin
            errors++;
            $display("FAIL empty_pp: vld=%b count=%0d, required 0 1", rd_valid, count);
        end
        @(posedge CLK); #1;
        do_pop(v, a, d);
        ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
        checks++;
        if (v !== 1'b1 || a !== ea || d !== ed || count !== '0) begin
            errors++;
            $display("FAIL empty_pp_pop: vld=%b addr=%h data=%h count=%0d, required 1 %h %h 0", v, a, d, count, ea, ed);
        end
    endtask

`ifdef STORE_LOGGER_TIMESTAMP_EN
    task automatic test_timestamp();
        logic v; logic [31:0] a, d;
        logic [31:0] t0;
        rst = 1'b1;
        @(posedge CLK); #1;
        rst = 1'b0;
        repeat (5) @(posedge CLK);
        #1; CS = 1'b1; WE = 1'b1; Addr_In = 32'h80; Data_In = 32'h1;
        @(posedge CLK); #1; CS = 1'b0; WE = 1'b0;
        repeat (3) @(posedge CLK);
        #1; CS = 1'b1; WE = 1'b1; Addr_In = 32'h84; Data_In = 32'h2;
        @(posedge CLK); #1; CS = 1'b0; WE = 1'b0;
        do_pop(v, a, d);
        t0 = rd_time;
        checks++;
        if (v !== 1'b1 || t0 !== 32'd5) begin
            errors++;
            $display("FAIL ts_first: vld=%b time=%0d, required 1 5", v, t0);
        end
        do_pop(v, a, d);
        checks++;
        if (v !== 1'b1 || rd_time !== 32'd9 || d !== 32'h2) begin
            errors++;
            $display("FAIL ts_second: vld=%b time=%0d data=%h, required 1 9 2", v, rd_time, d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_we_held();
        test_overflow();
        test_async_reset();
        test_full_push_pop();
        test_empty_push_pop();
`ifdef STORE_LOGGER_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end
endmodule
